// File: rtl/seg_scan_driver_if.sv
// Display-side bundle for the seven-segment scan driver: the value and masks
// going in, and the digit position, segment pattern and frame strobe coming out.
interface seg_scan_driver_if;
  logic [31:0] data;
  logic [7:0]  digit_en;
  logic [7:0]  dp_en;
  logic [2:0]  pos;
  logic [7:0]  seg;
  logic        frame_done;

  // Producer of the display value; consumes the scan outputs.
  modport master (
    output data, digit_en, dp_en,
    input  pos, seg, frame_done
  );

  // The scan driver itself.
  modport slave (
    input  data, digit_en, dp_en,
    output pos, seg, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan driver for an 8-digit common-anode seven-segment
// display. Each digit is selected for SCAN_DIV cycles; the first BLANK_CYC
// cycles of every slot are forced dark to hide ghosting while the digit
// select settles. The displayed value is latched once per frame so a
// mid-frame input change never shows a mix of old and new digits.
module seg_scan_driver #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_driver_if.slave  bus
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_LIM = DIV_W'(BLANK_CYC);

  generate
    if (SCAN_DIV < 2) begin : g_bad_div
      $error("seg_scan_driver: SCAN_DIV must be at least 2");
    end
    if (BLANK_CYC < 1 || BLANK_CYC >= SCAN_DIV) begin : g_bad_blank
      $error("seg_scan_driver: BLANK_CYC must satisfy 1 <= BLANK_CYC < SCAN_DIV");
    end
  endgenerate

  // Hex font, active-low, bits 6..0 = g,f,e,d,c,b,a.
  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    logic [6:0] f;
    case (nib)
      4'h0: f = 7'h40;
      4'h1: f = 7'h79;
      4'h2: f = 7'h24;
      4'h3: f = 7'h30;
      4'h4: f = 7'h19;
      4'h5: f = 7'h12;
      4'h6: f = 7'h02;
      4'h7: f = 7'h78;
      4'h8: f = 7'h00;
      4'h9: f = 7'h10;
      4'hA: f = 7'h08;
      4'hB: f = 7'h03;
      4'hC: f = 7'h46;
      4'hD: f = 7'h21;
      4'hE: f = 7'h06;
      default: f = 7'h0E;
    endcase
    return f;
  endfunction

  // Full cathode pattern: dark when not lit, otherwise dp plus font glyph.
  function automatic logic [7:0] seg_pattern(input logic       lit,
                                             input logic       dp_on,
                                             input logic [3:0] nib);
    logic [7:0] s;
    if (!lit) s = 8'hFF;
    else      s = {~dp_on, hex_font(nib)};
    return s;
  endfunction

  // Scan state and frame shadows
  logic [DIV_W-1:0] r_div_cnt;
  logic [2:0]       r_pos;
  logic [31:0]      r_data_s;
  logic [7:0]       r_digit_en_s;
  logic [7:0]       r_dp_en_s;
  logic [7:0]       r_seg;
  logic             r_frame_done;
  // Forces a shadow load on the first edge after reset, which does not
  // itself enter (pos=0, div_cnt=0).
  logic             r_load_pend;

  // Next-state values; the segment register is fed from these so that the
  // pattern always matches the pos being driven in the same cycle.
  logic             w_tick;
  logic [DIV_W-1:0] w_div_nxt;
  logic [2:0]       w_pos_nxt;
  logic             w_load;
  logic [31:0]      w_data_nxt;
  logic [7:0]       w_digit_en_nxt;
  logic [7:0]       w_dp_en_nxt;
  logic [3:0]       w_nib;
  logic             w_lit;
  logic [7:0]       w_seg_nxt;
  logic             w_frame_done_nxt;

  // Divider, position, shadow-load decision and next segment pattern.
  always_comb begin
    w_tick           = (r_div_cnt == DIV_LAST);
    w_div_nxt        = w_tick ? '0 : r_div_cnt + DIV_W'(1);
    w_pos_nxt        = w_tick ? r_pos + 3'd1 : r_pos;
    w_load           = r_load_pend || ((w_pos_nxt == 3'd0) && (w_div_nxt == '0));
    w_data_nxt       = w_load ? bus.data     : r_data_s;
    w_digit_en_nxt   = w_load ? bus.digit_en : r_digit_en_s;
    w_dp_en_nxt      = w_load ? bus.dp_en    : r_dp_en_s;
    w_nib            = 4'(w_data_nxt >> {w_pos_nxt, 2'b00});
    w_lit            = (w_div_nxt >= BLANK_LIM) && w_digit_en_nxt[w_pos_nxt];
    w_seg_nxt        = seg_pattern(w_lit, w_dp_en_nxt[w_pos_nxt], w_nib);
    w_frame_done_nxt = (w_pos_nxt == 3'd7) && (w_div_nxt == DIV_LAST);
  end

  // State update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt    <= '0;
      r_pos        <= 3'd0;
      r_data_s     <= 32'd0;
      r_digit_en_s <= 8'd0;
      r_dp_en_s    <= 8'd0;
      r_seg        <= 8'hFF;
      r_frame_done <= 1'b0;
      r_load_pend  <= 1'b1;
    end else begin
      r_div_cnt    <= w_div_nxt;
      r_pos        <= w_pos_nxt;
      r_data_s     <= w_data_nxt;
      r_digit_en_s <= w_digit_en_nxt;
      r_dp_en_s    <= w_dp_en_nxt;
      r_seg        <= w_seg_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_load_pend  <= 1'b0;
    end
  end

  assign bus.pos        = r_pos;
  assign bus.seg        = r_seg;
  assign bus.frame_done = r_frame_done;

endmodule
